lockout_ctrl: RTL and testbench

//  Downstream stage of the combination-lock checker. Consumes its grant/deny

---
 rtl/lockout_ctrl.sv | 154 +++++++++++++++
 tb/tb_lockout_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lockout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lockout_ctrl
//  Description : Downstream stage of the combination-lock checker. Consumes
//                grant/deny result pulses, drives the door relay, counts
//                consecutive failed attempts and enforces a timed lockout
//                after MAX_FAILS of them. Gates the user's enter button so
//                the checker cannot be re-armed while open or locked out.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  clock, rising edge
//    rst          in   1  asynchronous, active-high reset
//    grant_in     in   1  1-cycle pulse from checker: correct code
//    deny_in      in   1  1-cycle pulse from checker: wrong code
//    enter_req    in   1  enter button (already synchronised)
//    enter_gated  out  1  enter forwarded to checker, only while READY
//    unlock       out  1  door relay drive, registered
//    lock         out  1  lockout indicator, registered
//    fail_cnt     out  4  consecutive-fail count, registered
//  Optional (macro ALARM_EN):
//    alarm        out  1  1-cycle registered pulse on each lockout entry
//    lock_events  out  8  lockouts since reset, saturating at 255
// ============================================================================
module lockout_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       grant_in,
  input  logic       deny_in,
  input  logic       enter_req,
  output logic       enter_gated,
  output logic       unlock,
  output logic       lock,
  output logic [3:0] fail_cnt
`ifdef ALARM_EN
  ,
  output logic       alarm,
  output logic [7:0] lock_events
`endif
);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_OPEN   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Timers are loaded with N-1 so that the output stays high for exactly N
  // cycles: the loading edge plus N-1 decrement edges.
  localparam logic [TMR_W-1:0] C_UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]       C_MAX_FAILS    = 4'(MAX_FAILS);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [3:0]       r_fail_cnt;
  logic             r_unlock;
  logic             r_lock;
  logic [4:0]       w_fail_inc;
  logic             w_fail_limit;

  // One bit wider so the compare cannot be fooled by a 4-bit wrap.
  assign w_fail_inc   = {1'b0, r_fail_cnt} + 5'd1;
  assign w_fail_limit = (w_fail_inc == {1'b0, C_MAX_FAILS});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_READY;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_unlock   <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      case (r_state)
        ST_READY: begin
          // A simultaneous grant and deny is treated as a deny (fail-safe).
          if (deny_in) begin
            if (w_fail_limit) begin
              r_state    <= ST_LOCKED;
              r_timer    <= C_LOCKOUT_LOAD;
              r_fail_cnt <= C_MAX_FAILS;
              r_lock     <= 1'b1;
            end else begin
              r_fail_cnt <= w_fail_inc[3:0];
            end
          end else if (grant_in) begin
            r_state    <= ST_OPEN;
            r_timer    <= C_UNLOCK_LOAD;
            r_fail_cnt <= '0;
            r_unlock   <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (r_timer == '0) begin
            r_state  <= ST_READY;
            r_unlock <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_LOCKED: begin
          if (r_timer == '0) begin
            r_state    <= ST_READY;
            r_lock     <= 1'b0;
            r_fail_cnt <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_READY;
          r_timer  <= '0;
          r_unlock <= 1'b0;
          r_lock   <= 1'b0;
        end
      endcase
    end
  end

  assign enter_gated = enter_req & (r_state == ST_READY);
  assign unlock      = r_unlock;
  assign lock        = r_lock;
  assign fail_cnt    = r_fail_cnt;

`ifdef ALARM_EN
  logic       r_alarm;
  logic [7:0] r_lock_events;
  logic       w_lock_entry;

  assign w_lock_entry = (r_state == ST_READY) && deny_in && w_fail_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm       <= 1'b0;
      r_lock_events <= '0;
    end else begin
      r_alarm <= w_lock_entry;
      if (w_lock_entry && (r_lock_events != 8'hFF)) begin
        r_lock_events <= r_lock_events + 8'd1;
      end
    end
  end

  assign alarm       = r_alarm;
  assign lock_events = r_lock_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lockout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lockout_ctrl
//  Description : Directed self-checking bench for lockout_ctrl with
//                MAX_FAILS=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lockout_ctrl;

  logic       clk;
  logic       rst;
  logic       grant_in;
  logic       deny_in;
  logic       enter_req;
  logic       enter_gated;
  logic       unlock;
  logic       lock;
  logic [3:0] fail_cnt;
`ifdef ALARM_EN
  logic       alarm;
  logic [7:0] lock_events;
`endif

  int passed;
  int total;

  lockout_ctrl #(
    .MAX_FAILS     (3),
    .UNLOCK_CYCLES (4),
    .LOCKOUT_CYCLES(8),
    .TMR_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .grant_in   (grant_in),
    .deny_in    (deny_in),
    .enter_req  (enter_req),
    .enter_gated(enter_gated),
    .unlock     (unlock),
    .lock       (lock),
    .fail_cnt   (fail_cnt)
`ifdef ALARM_EN
    ,
    .alarm      (alarm),
    .lock_events(lock_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic g, input logic d);
    grant_in = g;
    deny_in  = d;
    tick();
    grant_in = 1'b0;
    deny_in  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    grant_in  = 1'b0;
    deny_in   = 1'b0;
    enter_req = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_unlock", unlock, 0);
    chk("rst_lock", lock, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_gate", enter_gated, 1);
    rst = 1'b0;
    tick();

    // Grant: unlock for exactly 4 cycles, enter blocked meanwhile
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("open_unlock", unlock, 1);
      chk("open_gate", enter_gated, 0);
      tick();
    end
    chk("open_end_unlock", unlock, 0);
    chk("open_end_gate", enter_gated, 1);

    // deny, deny, grant: partial count cleared by grant
    pulse(1'b0, 1'b1);
    chk("dd_fail1", fail_cnt, 1);
    pulse(1'b0, 1'b1);
    chk("dd_fail2", fail_cnt, 2);
    chk("dd_nolock", lock, 0);
    pulse(1'b1, 1'b0);
    chk("ddg_fail0", fail_cnt, 0);
    chk("ddg_unlock", unlock, 1);
    chk("ddg_nolock", lock, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("ddg_end_unlock", unlock, 0);

    // Three denies: lockout for exactly 8 cycles, pulses inside ignored
    pulse(1'b0, 1'b1);
    chk("lk_fail1", fail_cnt, 1);
    pulse(1'b0, 1'b1);
    chk("lk_fail2", fail_cnt, 2);
    pulse(1'b0, 1'b1);
`ifdef ALARM_EN
    chk("lk_alarm_on", alarm, 1);
    chk("lk_events1", lock_events, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("lk_lock", lock, 1);
      chk("lk_fail3", fail_cnt, 3);
      chk("lk_unlock", unlock, 0);
      chk("lk_gate", enter_gated, 0);
      grant_in = (i == 2);
      deny_in  = (i == 5);
      tick();
`ifdef ALARM_EN
      chk("lk_alarm_off", alarm, 0);
`endif
    end
    grant_in = 1'b0;
    deny_in  = 1'b0;
    chk("lk_end_lock", lock, 0);
    chk("lk_end_fail", fail_cnt, 0);
    chk("lk_end_unlock", unlock, 0);
    chk("lk_end_gate", enter_gated, 1);

    // Simultaneous grant and deny counts as deny
    pulse(1'b1, 1'b1);
    chk("gd_fail1", fail_cnt, 1);
    chk("gd_unlock", unlock, 0);
    chk("gd_lock", lock, 0);
    pulse(1'b1, 1'b0);
    chk("gd_clear", fail_cnt, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("gd_end_unlock", unlock, 0);

`ifdef ALARM_EN
    // Second lockout episode
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("al2_alarm_on", alarm, 1);
    chk("al2_lock", lock, 1);
    tick();
    chk("al2_alarm_off", alarm, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("al2_end_lock", lock, 0);
    chk("al2_events", lock_events, 2);
`endif

    // Asynchronous reset in the middle of a lockout
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    tick();
    chk("mid_lock_pre", lock, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_lock", lock, 0);
    chk("mid_rst_fail", fail_cnt, 0);
    chk("mid_rst_gate", enter_gated, 1);
`ifdef ALARM_EN
    chk("mid_rst_events", lock_events, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    enter_req = 1'b0;
    #1;
    chk("post_gate0", enter_gated, 0);
    enter_req = 1'b1;
    #1;
    chk("post_gate1", enter_gated, 1);
    chk("post_lock", lock, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
